// File: rtl/inst_fetch_if.sv
// inst_fetch_if -- handshake bundle between the fetch unit, the instruction
// memory, the PC-select logic and decode.
//   master : the fetch unit (drives imem_req/imem_addr and inst_*)
//   slave  : the surrounding system (redirect source, memory, decode)
// Signals:
//   redirect_valid/redirect_pc : taken-branch/jump redirect request
//   imem_req/imem_addr/imem_gnt : memory request channel (word addresses)
//   imem_rvalid/imem_rdata      : in-order memory responses
//   inst_valid/inst_data/inst_pc/inst_ready : decode-side instruction stream
interface inst_fetch_if #(
  parameter int DATA_W = 32
);
  logic              redirect_valid;
  logic [DATA_W-1:0] redirect_pc;
  logic              imem_req;
  logic [DATA_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;
  logic              inst_valid;
  logic [DATA_W-1:0] inst_data;
  logic [DATA_W-1:0] inst_pc;
  logic              inst_ready;

  modport master (
    input  redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata,
           inst_ready,
    output imem_req, imem_addr, inst_valid, inst_data, inst_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata,
           inst_ready,
    input  imem_req, imem_addr, inst_valid, inst_data, inst_pc
  );
endinterface

// File: rtl/inst_fetch.sv
// inst_fetch -- instruction fetch unit with a 4-entry {pc, inst} buffer.
// Issues word-addressed requests to an in-order instruction memory, tracks
// outstanding requests with a credit rule (buffer + in-flight <= 4) so a
// response always has a free slot, and discards stale responses after a
// redirect.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous active-high reset
//   bus   : inst_fetch_if.master (redirect, imem request/response, inst_*)
// Parameter:
//   RESET_PC : fetch address loaded on reset
// Build option:
//   IFETCH_BYPASS_EN : when defined, a response arriving with the buffer
//   empty is presented to decode in the same cycle; when undefined the
//   instruction outputs come from registers only (1-cycle response latency).
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic         clk,
  input  logic         reset,
  inst_fetch_if.master bus
);
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  function automatic logic [DATA_W-1:0] pc_inc(input logic [DATA_W-1:0] pc);
    return pc + 32'd1;  // natural 32-bit wrap from FFFFFFFF to 0
  endfunction

  logic [DATA_W-1:0] fetch_pc;
  logic [DATA_W-1:0] resp_pc;
  logic [2:0]        occ;
  logic [2:0]        outst;
  logic [2:0]        drop;
  logic [1:0]        rd_ptr;
  logic [1:0]        wr_ptr;
  logic [DATA_W-1:0] fifo_pc   [DEPTH];
  logic [DATA_W-1:0] fifo_inst [DEPTH];

  logic [3:0]        credit_used;
  logic              req_c;
  logic              req_fire;
  logic              rsp_keep;
  logic              rsp_drop;
  logic              fifo_empty;
  logic              bypass;
  logic              pop;
  logic              fifo_pop;
  logic              push;
  logic              inst_valid_c;
  logic [DATA_W-1:0] inst_data_c;
  logic [DATA_W-1:0] inst_pc_c;

  assign credit_used = {1'b0, occ} + {1'b0, outst};
  assign req_c       = !reset && !bus.redirect_valid && (credit_used < 4'(DEPTH));
  assign req_fire    = req_c && bus.imem_gnt;
  assign rsp_keep    = bus.imem_rvalid && (drop == 3'd0);
  assign rsp_drop    = bus.imem_rvalid && (drop != 3'd0);
  assign fifo_empty  = (occ == 3'd0);

`ifdef IFETCH_BYPASS_EN
  assign bypass = rsp_keep && fifo_empty && !bus.redirect_valid;
`else
  assign bypass = 1'b0;
`endif

  // Instruction presented to decode: buffer head, or the live response when
  // the bypass is built in and the buffer is empty.
  always_comb begin
    inst_valid_c = 1'b0;
    inst_data_c  = '0;
    inst_pc_c    = '0;
    if (!reset) begin
      inst_valid_c = !bus.redirect_valid && !fifo_empty;
      inst_data_c  = fifo_inst[rd_ptr];
      inst_pc_c    = fifo_pc[rd_ptr];
`ifdef IFETCH_BYPASS_EN
      if (bypass) begin
        inst_valid_c = 1'b1;
        inst_data_c  = bus.imem_rdata;
        inst_pc_c    = resp_pc;
      end
`endif
    end
  end

  assign pop      = inst_valid_c && bus.inst_ready;
  assign fifo_pop = pop && !fifo_empty;
  // A bypassed instruction consumed in its arrival cycle never enters the buffer.
  assign push     = rsp_keep && !bus.redirect_valid && !(bypass && bus.inst_ready);

  assign bus.imem_req   = req_c;
  assign bus.imem_addr  = fetch_pc;
  assign bus.inst_valid = inst_valid_c;
  assign bus.inst_data  = inst_data_c;
  assign bus.inst_pc    = inst_pc_c;

  // Control state: PCs, counters and buffer pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      occ      <= '0;
      outst    <= '0;
      drop     <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      outst <= outst + {2'b0, req_fire} - {2'b0, bus.imem_rvalid};
      if (bus.redirect_valid) begin
        fetch_pc <= bus.redirect_pc;
        resp_pc  <= bus.redirect_pc;
        occ      <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        // Everything still in flight after this cycle's response is stale.
        drop     <= outst - {2'b0, bus.imem_rvalid};
      end else begin
        if (req_fire) fetch_pc <= pc_inc(fetch_pc);
        if (rsp_keep) resp_pc  <= pc_inc(resp_pc);
        drop <= drop - {2'b0, rsp_drop};
        occ  <= occ + {2'b0, push} - {2'b0, fifo_pop};
        if (push)     wr_ptr <= wr_ptr + 2'd1;
        if (fifo_pop) rd_ptr <= rd_ptr + 2'd1;
      end
    end
  end

  // Buffer storage: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]   <= resp_pc;
      fifo_inst[wr_ptr] <= bus.imem_rdata;
    end
  end
endmodule
